// File: rtl/dense_feed_ctrl.sv
// dense_feed_ctrl
// Feature buffer and bus sequencer for the dense layer. It collects one
// flattened feature vector of ROWS*CH words. It then replays that vector on
// the shared currentData/counter1/counter2/start bus that every parallel
// dense neuron unit listens to. When all neuron sums are final it raises
// results_valid for one cycle.
//
// Optional build macro: DENSE_FEED_PINGPONG_EN
//   Undefined (default): one buffer bank. Input is only accepted while filling.
//   Defined: two buffer banks. The next frame is filled while the current
//   frame is replayed, and DONE chains straight into the next START.

module dense_feed_ctrl #(
  parameter int DATA_W = 16,
  parameter int CH     = 8,
  parameter int ROWS   = 16,
  parameter int CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] currentData,
  output logic [CNT_W-1:0]         counter1,
  output logic [CNT_W-1:0]         counter2,
  output logic                     start,
  output logic                     results_valid,
  output logic                     busy
);

  localparam int N_IN  = ROWS * CH;
  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
`ifdef DENSE_FEED_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int DEPTH  = NBANK * N_IN;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Sized copies of the loop limits so that counter compares stay width-clean
  localparam logic [CNT_W-1:0] CH_C     = CNT_W'(CH);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_IN - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Feature storage. It is not reset; its contents only matter after a full fill.
  logic signed [DATA_W-1:0] feat_buf [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              accept;
  logic              fill_last;

  assign accept    = in_valid && in_ready;
  assign fill_last = accept && (wr_ptr == PTR_LAST);

  // Flattened read index counter1*CH + counter2. It is only consumed while counter2 < CH.
  assign rd_idx = PTR_W'(32'(counter1) * 32'(CH) + 32'(counter2));

`ifdef DENSE_FEED_PINGPONG_EN
  logic wr_bank;
  logic rd_bank;
  logic pending;

  assign wr_addr = wr_bank ? (ADDR_W'(N_IN) + ADDR_W'(wr_ptr)) : ADDR_W'(wr_ptr);
  assign rd_addr = rd_bank ? (ADDR_W'(N_IN) + ADDR_W'(rd_idx)) : ADDR_W'(rd_idx);
`else
  assign wr_addr = ADDR_W'(wr_ptr);
  assign rd_addr = ADDR_W'(rd_idx);
`endif

  // Store each accepted feature word at the current write position
  always_ff @(posedge clk) begin
    if (accept) begin
      feat_buf[wr_addr] <= in_data;
    end
  end

  // Broadcast the buffered word on data steps; drive zero during fill, start and bubble cycles
  always_comb begin
    currentData = '0;
    if ((state == RUN) && (counter2 != CH_C)) begin
      currentData = feat_buf[rd_addr];
    end
  end

  // Sequencer: fill -> start pulse -> row/column sweep with a bubble per row -> done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      wr_ptr        <= '0;
      in_ready      <= 1'b1;
      counter1      <= '0;
      counter2      <= CH_C;
      start         <= 1'b0;
      results_valid <= 1'b0;
      busy          <= 1'b0;
`ifdef DENSE_FEED_PINGPONG_EN
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      pending       <= 1'b0;
`endif
    end else begin
      start         <= 1'b0;
      results_valid <= 1'b0;

      if (accept) begin
        wr_ptr <= fill_last ? '0 : wr_ptr + 1'b1;
      end

`ifdef DENSE_FEED_PINGPONG_EN
      // A bank that fills behind a running frame waits here until it is swapped in
      if (fill_last && (state != FILL)) begin
        pending  <= 1'b1;
        in_ready <= 1'b0;
      end
`endif

      case (state)
        FILL: begin
          if (fill_last) begin
            state    <= START;
            start    <= 1'b1;
            busy     <= 1'b1;
            counter1 <= '0;
            counter2 <= '0;
`ifdef DENSE_FEED_PINGPONG_EN
            rd_bank  <= wr_bank;
            wr_bank  <= ~wr_bank;
`else
            in_ready <= 1'b0;
`endif
          end
        end

        START: begin
          state <= RUN;
        end

        RUN: begin
          if (counter2 != CH_C) begin
            counter2 <= counter2 + 1'b1;
          end else if (counter1 == ROW_LAST) begin
            state         <= DONE;
            results_valid <= 1'b1;
          end else begin
            counter1 <= counter1 + 1'b1;
            counter2 <= '0;
          end
        end

        DONE: begin
`ifdef DENSE_FEED_PINGPONG_EN
          if (pending || fill_last) begin
            state    <= START;
            start    <= 1'b1;
            counter1 <= '0;
            counter2 <= '0;
            rd_bank  <= wr_bank;
            wr_bank  <= ~wr_bank;
            pending  <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            state    <= FILL;
            busy     <= 1'b0;
            counter1 <= '0;
            counter2 <= CH_C;
            in_ready <= 1'b1;
          end
`else
          state    <= FILL;
          busy     <= 1'b0;
          counter1 <= '0;
          counter2 <= CH_C;
          in_ready <= 1'b1;
`endif
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_feed_ctrl.sv
// tb_dense_feed_ctrl
// Scoreboard bench for dense_feed_ctrl with default parameters. When a frame's
// last word is accepted, the full expected output schedule is queued: the
// start cycle, the ROWS*(CH+1) run cycles and the results_valid cycle. One
// entry is then popped and compared on every following cycle. A small dense
// unit (weight 1.0 in Q10, bias 0) consumes the bus and its final sum is
// compared at results_valid.

module tb_dense_feed_ctrl;

  localparam int DATA_W  = 16;
  localparam int CH      = 8;
  localparam int ROWS    = 16;
  localparam int CNT_W   = 5;
  localparam int N_IN    = ROWS * CH;
  localparam int RUN_LEN = ROWS * (CH + 1);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic signed [DATA_W-1:0] currentData;
  logic [CNT_W-1:0]         counter1;
  logic [CNT_W-1:0]         counter2;
  logic                     start;
  logic                     results_valid;
  logic                     busy;

  always #5 clk = ~clk;

  dense_feed_ctrl #(
    .DATA_W(DATA_W),
    .CH    (CH),
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .currentData  (currentData),
    .counter1     (counter1),
    .counter2     (counter2),
    .start        (start),
    .results_valid(results_valid),
    .busy         (busy)
  );

  typedef struct {
    logic                     start;
    logic                     rv;
    logic                     busy;
    logic                     ready;
    int                       c1;
    int                       c2;
    logic signed [DATA_W-1:0] data;
    bit                       chk_sum;
    longint                   sum;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;

  logic signed [DATA_W-1:0] frame_data [N_IN];
  int     fill_cnt      = 0;
  int     frames_done   = 0;
  bit     cur_exp_ready = 1'b1;
  longint acc           = 0;

  // Single comparison point: counts every check and reports each mismatch
  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the expected bus behaviour for the frame just completed
  task automatic pushSchedule();
    exp_t   e;
    longint s;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += longint'(frame_data[i]);
    e.start = 1'b1; e.rv = 1'b0; e.busy = 1'b1; e.ready = 1'b0;
    e.c1 = 0; e.c2 = 0; e.data = '0; e.chk_sum = 1'b0; e.sum = 0;
    sb.push_back(e);
    for (int n = 0; n < RUN_LEN; n++) begin
      e.start = 1'b0;
      e.c1    = n / (CH + 1);
      e.c2    = n % (CH + 1);
      e.data  = (e.c2 < CH) ? frame_data[e.c1 * CH + e.c2] : '0;
      sb.push_back(e);
    end
    e.rv = 1'b1; e.c1 = ROWS - 1; e.c2 = CH; e.data = '0;
    e.chk_sum = 1'b1; e.sum = s;
    sb.push_back(e);
  endtask

  // Compare one cycle of outputs against the scoreboard or the idle fill state
  task automatic checkCycle();
    exp_t e;
    if (start) acc = 0;
    else if (int'(counter2) < CH) acc += longint'(currentData) * 1024;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("start",         start,         e.start);
      checkOutput("results_valid", results_valid, e.rv);
      checkOutput("busy",          busy,          e.busy);
      checkOutput("in_ready",      in_ready,      e.ready);
      checkOutput("counter1",      counter1,      e.c1);
      checkOutput("counter2",      counter2,      e.c2);
      checkOutput("currentData",   longint'(currentData), longint'(e.data));
      if (e.chk_sum) checkOutput("outputSum", acc >>> 10, e.sum);
      cur_exp_ready = e.ready;
    end else begin
      checkOutput("fill_start",    start,         0);
      checkOutput("fill_rv",       results_valid, 0);
      checkOutput("fill_busy",     busy,          0);
      checkOutput("fill_in_ready", in_ready,      1);
      checkOutput("fill_counter1", counter1,      0);
      checkOutput("fill_counter2", counter2,      CH);
      checkOutput("fill_data",     longint'(currentData), 0);
      cur_exp_ready = 1'b1;
    end
  endtask

  // Drive one cycle of input, record any expected handshake, then check outputs
  task automatic applyStimulus(input bit v, input logic signed [DATA_W-1:0] d);
    bit hs;
    in_valid = v;
    in_data  = d;
    hs = v && cur_exp_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      frame_data[fill_cnt] = d;
      fill_cnt++;
      if (fill_cnt == N_IN) begin
        fill_cnt = 0;
        frames_done++;
        pushSchedule();
      end
    end
    checkCycle();
  endtask

  // Feed one full frame: mode 0 index data, 1 constant data, 2 random data with random valid
  task automatic fillFrame(input int mode, input int val);
    int                       target;
    bit                       v;
    logic signed [DATA_W-1:0] d;
    target = frames_done + 1;
    for (int i = 0; i < 8 * N_IN && frames_done < target; i++) begin
      v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0:       d = DATA_W'(fill_cnt);
        1:       d = DATA_W'(val);
        default: d = DATA_W'($urandom);
      endcase
      applyStimulus(v, d);
    end
    checkOutput("fill_complete", frames_done, target);
  endtask

  // Step until the queued schedule is consumed, bounded by a cycle budget
  task automatic drain(input bit hold_valid);
    for (int i = 0; i < RUN_LEN + 10 && sb.size() > 0; i++) begin
      applyStimulus(hold_valid, DATA_W'($urandom));
    end
    checkOutput("drain_left", sb.size(), 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    repeat (3) begin
      @(posedge clk);
      #1;
      checkCycle();
    end
    reset = 1'b0;

    $display("[TB] frame with index data");
    fillFrame(0, 0);
    drain(1'b0);

    $display("[TB] dense sum frames: +8 then -4");
    fillFrame(1, 8);
    drain(1'b0);
    fillFrame(1, -4);
    drain(1'b1);

    $display("[TB] random valid gaps, valid held during run");
    fillFrame(2, 0);
    drain(1'b1);

    $display("[TB] reset in the middle of a run");
    fillFrame(0, 0);
    for (int i = 0; i < 51; i++) applyStimulus(1'b0, '0);
    reset = 1'b1;
    #1;
    checkOutput("rst_counter2", counter2,      CH);
    checkOutput("rst_counter1", counter1,      0);
    checkOutput("rst_start",    start,         0);
    checkOutput("rst_rv",       results_valid, 0);
    checkOutput("rst_in_ready", in_ready,      1);
    checkOutput("rst_data",     longint'(currentData), 0);
    sb.delete();
    fill_cnt      = 0;
    cur_exp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkCycle();
    reset = 1'b0;

    $display("[TB] idle fill state, then clean refill");
    for (int i = 0; i < 140; i++) applyStimulus(1'b0, '0);
    fillFrame(2, 0);
    drain(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
